// File: rtl/read_data_router.sv
// read_data_router: in-order read-data steering from slaves to one master with burst tracking
// Each accepted address pushes {sel, len}; the head entry steers data and counts beats until its last beat pops it.
module read_data_router #(
  parameter int num_slaves = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                a_hs,
  input  logic [2:0]                          a_sel,
  input  logic [7:0]                          a_len,
  output logic                                q_full,
  input  logic [num_slaves-1:0][DATA_W-1:0]   s_rdata,
  input  logic [num_slaves-1:0][1:0]          s_rresp,
  input  logic [num_slaves-1:0]               s_rlast,
  input  logic [num_slaves-1:0]               s_rvalid,
  output logic [num_slaves-1:0]               s_rready,
  output logic [DATA_W-1:0]                   m_rdata,
  output logic [1:0]                          m_rresp,
  output logic                                m_rlast,
  output logic                                m_rvalid,
  input  logic                                m_rready,
  input  logic                                err_clr,
  output logic                                err_overflow,
  output logic                                err_last
);
  localparam int AW = $clog2(DEPTH);
  logic [2:0] sel_q [DEPTH];
  logic [7:0] len_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [7:0] beat, head_len;
  logic [2:0] head_sel, idx;
  logic empty, hit, beat_hs, push, pop;
  assign empty = count == '0;
  assign q_full = count == (AW+1)'(DEPTH);
  assign head_sel = sel_q[rd_ptr];
  assign head_len = len_q[rd_ptr];
  assign hit = 32'(head_sel) < num_slaves;
  // Index clamped so a decode-error head never reads past the slave arrays
  assign idx = hit ? head_sel : 3'd0;
  always_comb begin
    m_rvalid = !empty && (hit ? s_rvalid[idx] : 1'b1);
    m_rdata = (!empty && hit) ? s_rdata[idx] : '0;
    m_rresp = empty ? 2'b00 : (hit ? s_rresp[idx] : 2'b11);
    m_rlast = !empty && (beat == head_len);
    s_rready = (!empty && hit && m_rready) ? num_slaves'(1) << idx : '0;
  end
  assign beat_hs = m_rvalid && m_rready;
  assign pop = beat_hs && m_rlast;
  assign push = a_hs && !q_full;
  always_ff @(posedge clk) begin
    if (push) begin
      sel_q[wr_ptr] <= a_sel;
      len_q[wr_ptr] <= a_len;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      beat <= '0;
      err_overflow <= 1'b0;
      err_last <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      beat <= pop ? '0 : beat + 8'(beat_hs);
      err_overflow <= (a_hs && q_full) || (err_overflow && !err_clr);
      err_last <= (beat_hs && hit && (s_rlast[idx] != m_rlast)) || (err_last && !err_clr);
    end
  end
endmodule

// File: tb/tb_read_data_router.sv
// tb_read_data_router: directed vector table, corner-case sequences and randomized traffic vs a queue model
module tb_read_data_router;
  localparam int NS = 5, DW = 32, DEPTH = 4;
  logic clk = 0, reset = 0;
  logic a_hs, q_full, m_rlast, m_rvalid, m_rready, err_clr, err_overflow, err_last;
  logic [2:0] a_sel;
  logic [7:0] a_len;
  logic [NS-1:0][DW-1:0] s_rdata;
  logic [NS-1:0][1:0] s_rresp;
  logic [NS-1:0] s_rlast, s_rvalid, s_rready;
  logic [DW-1:0] m_rdata;
  logic [1:0] m_rresp;
  always #5 clk = ~clk;

  read_data_router #(.num_slaves(NS), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .a_hs(a_hs), .a_sel(a_sel), .a_len(a_len), .q_full(q_full),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .err_clr(err_clr), .err_overflow(err_overflow), .err_last(err_last)
  );

  int checks = 0, errors = 0;
  typedef struct {int sel; int len;} ent_t;
  ent_t mq[$];
  int mbeat = 0;
  bit meo = 0, mel = 0;

  typedef struct {
    logic hs; logic [2:0] sel; logic [7:0] len; logic [4:0] vld, rl; logic rdy;
    logic ev, el; logic [1:0] er; logic [4:0] erdy; logic ef; int src;
  } vec_t;
  vec_t tv[16];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic idle();
    a_hs = 0; a_sel = 0; a_len = 0; s_rvalid = '0; s_rlast = '0; m_rready = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    mq.delete(); mbeat = 0; meo = 0; mel = 0;
    @(posedge clk); #1;
    reset = 1;
  endtask

  // Compare outputs against the queue model mid-cycle, then advance the model across the edge
  task automatic cyc(input string tag);
    logic ev, el;
    logic [DW-1:0] ed;
    logic [1:0] er;
    logic [NS-1:0] erdy;
    bit full, hs, lerr;
    #4;
    full = mq.size() == DEPTH;
    ev = 0; ed = '0; er = 0; el = 0; erdy = '0; lerr = 0;
    if (mq.size() > 0) begin
      el = mbeat == mq[0].len;
      if (mq[0].sel < NS) begin
        ev = s_rvalid[mq[0].sel]; ed = s_rdata[mq[0].sel]; er = s_rresp[mq[0].sel];
        erdy[mq[0].sel] = m_rready;
        lerr = s_rlast[mq[0].sel] != el;
      end else begin
        ev = 1; er = 2'b11;
      end
    end
    chk({tag, ".m_rvalid"}, m_rvalid, ev);
    chk({tag, ".m_rdata"}, m_rdata, ed);
    chk({tag, ".m_rresp"}, m_rresp, er);
    chk({tag, ".m_rlast"}, m_rlast, el);
    chk({tag, ".s_rready"}, s_rready, erdy);
    chk({tag, ".q_full"}, q_full, full);
    chk({tag, ".err_overflow"}, err_overflow, meo);
    chk({tag, ".err_last"}, err_last, mel);
    hs = ev && m_rready;
    meo = (a_hs && full) || (meo && !err_clr);
    mel = (hs && lerr) || (mel && !err_clr);
    if (hs) begin
      if (el) begin void'(mq.pop_front()); mbeat = 0; end
      else mbeat++;
    end
    if (a_hs && !full) begin
      ent_t e;
      e.sel = int'(a_sel); e.len = int'(a_len);
      mq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tv[0]  = '{0, 0, 0, 5'b00000, 5'b00000, 1, 0, 0, 2'd0, 5'b00000, 0, -1};
    tv[1]  = '{1, 2, 3, 5'b00100, 5'b00000, 1, 0, 0, 2'd0, 5'b00000, 0, -1};
    tv[2]  = '{0, 0, 0, 5'b00100, 5'b00000, 1, 1, 0, 2'd2, 5'b00100, 0, 2};
    tv[3]  = tv[2];
    tv[4]  = tv[2];
    tv[5]  = '{0, 0, 0, 5'b00100, 5'b00100, 1, 1, 1, 2'd2, 5'b00100, 0, 2};
    tv[6]  = '{0, 0, 0, 5'b00100, 5'b00000, 1, 0, 0, 2'd0, 5'b00000, 0, -1};
    tv[7]  = '{1, 6, 2, 5'b00000, 5'b00000, 1, 0, 0, 2'd0, 5'b00000, 0, -1};
    tv[8]  = '{0, 0, 0, 5'b00000, 5'b00000, 1, 1, 0, 2'd3, 5'b00000, 0, -1};
    tv[9]  = tv[8];
    tv[10] = '{0, 0, 0, 5'b00000, 5'b00000, 1, 1, 1, 2'd3, 5'b00000, 0, -1};
    tv[11] = tv[0];
    tv[12] = '{1, 0, 0, 5'b00000, 5'b00000, 1, 0, 0, 2'd0, 5'b00000, 0, -1};
    tv[13] = '{0, 0, 0, 5'b01001, 5'b00000, 0, 1, 1, 2'd0, 5'b00000, 0, 0};
    tv[14] = '{0, 0, 0, 5'b01001, 5'b00001, 1, 1, 1, 2'd0, 5'b00001, 0, 0};
    tv[15] = '{0, 0, 0, 5'b01001, 5'b00000, 1, 0, 0, 2'd0, 5'b00000, 0, -1};

    idle(); s_rdata = '0; s_rresp = '0;
    #2;
    chk("rst.q_full", q_full, 0);
    chk("rst.m_rvalid", m_rvalid, 0);
    chk("rst.s_rready", s_rready, 0);
    chk("rst.err_overflow", err_overflow, 0);
    chk("rst.err_last", err_last, 0);
    @(posedge clk); #1;
    reset = 1;

    for (int k = 0; k < 16; k++) begin
      logic [DW-1:0] ed;
      a_hs = tv[k].hs; a_sel = tv[k].sel; a_len = tv[k].len;
      s_rvalid = tv[k].vld; s_rlast = tv[k].rl; m_rready = tv[k].rdy; err_clr = 0;
      for (int i = 0; i < NS; i++) begin
        s_rdata[i] = DW'(32'h1000_0000 * (i + 1) + k);
        s_rresp[i] = 2'(i);
      end
      ed = tv[k].src < 0 ? '0 : DW'(32'h1000_0000 * (tv[k].src + 1) + k);
      #4;
      chk($sformatf("vec%0d.m_rvalid", k), m_rvalid, tv[k].ev);
      chk($sformatf("vec%0d.m_rlast", k), m_rlast, tv[k].el);
      chk($sformatf("vec%0d.m_rresp", k), m_rresp, tv[k].er);
      chk($sformatf("vec%0d.s_rready", k), s_rready, tv[k].erdy);
      chk($sformatf("vec%0d.q_full", k), q_full, tv[k].ef);
      chk($sformatf("vec%0d.m_rdata", k), m_rdata, ed);
      @(posedge clk); #1;
    end

    // In-order routing: slave 4 waits behind slave 1
    do_reset(); idle();
    a_hs = 1; a_sel = 1; a_len = 0; cyc("ord_push1");
    a_sel = 4; a_len = 1; s_rvalid = 5'b10000; m_rready = 1; cyc("ord_push2");
    a_hs = 0; cyc("ord_stall"); cyc("ord_stall");
    chk("ord_stall_rdy4", s_rready[4], 0);
    s_rvalid = 5'b10010; s_rlast = 5'b00010; cyc("ord_s1");
    s_rvalid = 5'b10000; s_rlast = 5'b00000; cyc("ord_s4b0");
    s_rlast = 5'b10000; cyc("ord_s4b1");
    idle(); cyc("ord_done");

    // Full queue, overflow, error clear, push/pop at full and at DEPTH-1
    do_reset(); idle();
    a_hs = 1;
    for (int i = 0; i < 4; i++) begin a_sel = 3'(i); a_len = 0; cyc("ovf_push"); end
    a_sel = 2; cyc("ovf_fifth");
    a_hs = 0; cyc("ovf_hold");
    chk("ovf_flag", err_overflow, 1);
    err_clr = 1; cyc("ovf_clr");
    err_clr = 0;
    chk("ovf_cleared", err_overflow, 0);
    s_rvalid = 5'b00001; s_rlast = 5'b00001; m_rready = 1; a_hs = 1; a_sel = 4; cyc("full_pushpop");
    s_rvalid = 5'b00010; s_rlast = 5'b00010; cyc("cnt3_pushpop");
    a_hs = 0; s_rvalid = '0; cyc("cnt3_after");
    chk("cnt3_notfull", q_full, 0);
    a_hs = 1; a_sel = 5; cyc("cnt3_refill");
    a_hs = 0;
    chk("cnt3_refull", q_full, 1);
    s_rvalid = '1; s_rlast = '1; err_clr = 1;
    repeat (6) cyc("drain");

    // Slave last flag early: error flagged but the count still governs the pop
    do_reset(); idle();
    a_hs = 1; a_sel = 0; a_len = 1; cyc("lm_push");
    a_hs = 0; s_rvalid = 5'b00001; s_rlast = 5'b00001; m_rready = 1; cyc("lm_b0");
    chk("lm_flag", err_last, 1);
    s_rlast = 5'b00000; cyc("lm_b1");
    cyc("lm_empty");

    // Longest burst on a decode-error slot: 256 beats
    do_reset(); idle();
    a_hs = 1; a_sel = 7; a_len = 255; cyc("l255_push");
    a_hs = 0; m_rready = 1;
    repeat (256) cyc("l255");
    cyc("l255_done");

    // Reset in the middle of a burst
    do_reset(); idle();
    a_hs = 1; a_sel = 3; a_len = 3; cyc("rst_push");
    a_hs = 0; s_rvalid = 5'b01000; m_rready = 1; s_rdata[3] = 32'hCAFE_0001;
    cyc("rst_b0"); cyc("rst_b1");
    reset = 0; #1;
    chk("rst_mid.m_rvalid", m_rvalid, 0);
    chk("rst_mid.s_rready", s_rready, 0);
    chk("rst_mid.q_full", q_full, 0);
    chk("rst_mid.m_rdata", m_rdata, 0);
    chk("rst_mid.m_rlast", m_rlast, 0);
    mq.delete(); mbeat = 0; meo = 0; mel = 0;
    @(posedge clk); #1;
    chk("rst_hold.m_rvalid", m_rvalid, 0);
    reset = 1;
    a_hs = 1; a_sel = 3; a_len = 1; cyc("rst_fresh_push");
    a_hs = 0; s_rlast = 5'b00000; cyc("rst_fresh_b0");
    s_rlast = 5'b01000; cyc("rst_fresh_b1");
    idle(); cyc("rst_fresh_done");

    // Randomized traffic
    do_reset(); idle();
    for (int n = 0; n < 1500; n++) begin
      a_hs = $urandom_range(0, 3) == 0;
      a_sel = 3'($urandom_range(0, 7));
      a_len = 8'($urandom_range(0, 3));
      s_rvalid = NS'($urandom);
      s_rlast = NS'($urandom);
      m_rready = $urandom_range(0, 3) != 0;
      err_clr = $urandom_range(0, 15) == 0;
      for (int i = 0; i < NS; i++) begin
        s_rdata[i] = $urandom;
        s_rresp[i] = 2'($urandom);
      end
      cyc("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
